// File: rtl/mmio_uart_tx.sv
// Debug-console UART transmitter: CPU stores fill a small FIFO, bytes leave as 8N1 frames on tx.
// Back-to-back frames are seamless; a new start bit follows the stop bit with no idle gap.
module mmio_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned DATA_W       = 8
) (
  input  logic                    CLK,
  input  logic                    rst,
  input  logic                    we,
  input  logic [DATA_W-1:0]       wdata,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    tx,
  output logic                    busy
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned TMR_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t              state_q,   state_d;
  logic [TMR_W-1:0]    timer_q,   timer_d;
  logic [BIT_W-1:0]    bit_idx_q, bit_idx_d;
  logic [DATA_W-1:0]   shift_q,   shift_d;
  logic                tx_q,      tx_d;
  logic [PTR_W-1:0]    wr_ptr_q,  wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q,  rd_ptr_d;
  logic [CNT_W-1:0]    count_q,   count_d;
  logic                full_q,    full_d;
  logic                empty_q,   empty_d;
  logic                busy_q,    busy_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic wr_en;
  logic pop;
  logic last_tick;

  // FIFO storage carries no reset; the pointers define what is valid.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    wr_en     = we & ~full_q;
    last_tick = (timer_q == TMR_W'(CLKS_PER_BIT - 1));

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!empty_q) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          timer_d = '0;
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (last_tick) begin
          timer_d   = '0;
          bit_idx_d = '0;
          state_d   = DATA;
          tx_d      = shift_q[0];
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      DATA: begin
        if (last_tick) begin
          timer_d = '0;
          shift_d = shift_q >> 1;
          if (bit_idx_q == BIT_W'(DATA_W - 1)) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + BIT_W'(1);
            tx_d      = shift_d[0];
          end
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      STOP: begin
        if (last_tick) begin
          timer_d = '0;
          if (!empty_q) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = START;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Occupancy bookkeeping; a same-edge write and pop leave count unchanged.
    wr_ptr_d = wr_ptr_q + PTR_W'(wr_en);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q;
    if (wr_en && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!wr_en && pop) begin
      count_d = count_q - CNT_W'(1);
    end
    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == '0);
    busy_d  = (state_d != IDLE) | ~empty_d;
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      busy_q    <= busy_d;
    end
  end

  assign full  = full_q;
  assign empty = empty_q;
  assign count = count_q;
  assign tx    = tx_q;
  assign busy  = busy_q;

endmodule
